mcif_axi_slave_ram: RTL and testbench

AXI4 slave responder that terminates the feature MCIF master (4 read clients, 2 write clients) on an on-chip RAM. It serves as the memory-side end of that AXI port, in system simulation and in small-buffer FPGA builds.
- Independent write path (AW/W/B) and read path (AR/R) share one byte-strobed, dual-port, read-first RAM.
- Supports INCR bursts up to 2^`log2AXI_BURST_LEN beats, one outstanding transaction per direction.

---
 rtl/mcif_axi_pkg.sv | 29 ++
 rtl/mcif_bram_be.sv | 31 +++
 rtl/mcif_axi_slave_ram.sv | 175 +++++++++++++++++
 tb/tb_mcif_axi_slave_ram.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcif_axi_pkg.sv
// Shared constants, FSM state types and address helper for the MCIF AXI slave RAM.
package mcif_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FIRST = 2'd1,
    R_DATA  = 2'd2
  } rstate_e;

  // Number of byte-offset address bits below the word index.
  function automatic int unsigned byte_lsb(input int unsigned data_width);
    int unsigned n;
    n = 0;
    for (int unsigned w = data_width / 8; w > 1; w = w >> 1) n++;
    return n;
  endfunction

endpackage

// File: rtl/mcif_bram_be.sv
// Simple dual-port RAM: byte-enabled write on port A, registered read-first read on port B.
module mcif_bram_be #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
        if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Separate non-blocking read returns the pre-write word on a same-address collision.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mcif_axi_slave_ram.sv
// AXI4 slave terminating the MCIF master on an on-chip RAM; independent write and read FSMs.
module mcif_axi_slave_ram
  import mcif_axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [31:0]             S_AXI_AWADDR,
  input  logic [LEN_WIDTH-1:0]    S_AXI_AWLEN,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [31:0]             S_AXI_ARADDR,
  input  logic [LEN_WIDTH-1:0]    S_AXI_ARLEN,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_RID,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic                    wlast_err
);

  localparam int unsigned LSB = byte_lsb(DATA_WIDTH);

  wstate_e               wstate;
  logic [ID_WIDTH-1:0]   wid;
  logic [DEPTH_LOG2-1:0] widx;
  logic [LEN_WIDTH-1:0]  wlen;
  logic [LEN_WIDTH-1:0]  wcnt;
  logic                  wr_fire;
  logic                  wr_end;

  rstate_e               rstate;
  logic [ID_WIDTH-1:0]   rid;
  logic [DEPTH_LOG2-1:0] ridx;
  logic [LEN_WIDTH-1:0]  rlen;
  logic [LEN_WIDTH-1:0]  rcnt;
  logic [LEN_WIDTH-1:0]  rcnt_nxt;
  logic                  rd_en;
  logic                  unused_bits;

  assign unused_bits = ^{S_AXI_AWBURST, S_AXI_AWADDR, S_AXI_ARADDR};

  assign wr_fire     = S_AXI_WVALID && S_AXI_WREADY;
  assign wr_end      = (wcnt == wlen);
  assign S_AXI_BID   = wid;
  assign S_AXI_BRESP = AXI_RESP_OKAY;

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate        <= W_IDLE;
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      wlast_err     <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (S_AXI_AWVALID) begin
            wid           <= S_AXI_AWID;
            widx          <= S_AXI_AWADDR[LSB +: DEPTH_LOG2];
            wlen          <= S_AXI_AWLEN;
            wcnt          <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            wstate        <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_fire) begin
            widx <= widx + DEPTH_LOG2'(1);
            wcnt <= wcnt + LEN_WIDTH'(1);
            if (S_AXI_WLAST != wr_end) wlast_err <= 1'b1;
            if (wr_end) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              wstate       <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            wstate        <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Next beat is fetched in the same cycle as the current handshake so RDATA streams back-to-back.
  assign rd_en = (rstate == R_FIRST) ||
                 ((rstate == R_DATA) && S_AXI_RREADY && !S_AXI_RLAST);
  assign rcnt_nxt    = rcnt + LEN_WIDTH'(1);
  assign S_AXI_RID   = rid;
  assign S_AXI_RRESP = AXI_RESP_OKAY;

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate        <= R_IDLE;
      S_AXI_ARREADY <= 1'b1;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            rid           <= S_AXI_ARID;
            ridx          <= S_AXI_ARADDR[LSB +: DEPTH_LOG2];
            rlen          <= S_AXI_ARLEN;
            rcnt          <= '0;
            S_AXI_ARREADY <= 1'b0;
            rstate        <= R_FIRST;
          end
        end
        R_FIRST: begin
          ridx         <= ridx + DEPTH_LOG2'(1);
          S_AXI_RVALID <= 1'b1;
          S_AXI_RLAST  <= (rlen == '0);
          rstate       <= R_DATA;
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            if (S_AXI_RLAST) begin
              S_AXI_RVALID  <= 1'b0;
              S_AXI_RLAST   <= 1'b0;
              S_AXI_ARREADY <= 1'b1;
              rstate        <= R_IDLE;
            end else begin
              rcnt        <= rcnt_nxt;
              ridx        <= ridx + DEPTH_LOG2'(1);
              S_AXI_RLAST <= (rcnt_nxt == rlen);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  mcif_bram_be #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (widx),
    .wbe   (S_AXI_WSTRB),
    .wdata (S_AXI_WDATA),
    .re    (rd_en),
    .raddr (ridx),
    .rdata (S_AXI_RDATA)
  );

endmodule

// File: tb/tb_mcif_axi_slave_ram.sv
// Randomized bench for mcif_axi_slave_ram against a word-array memory model and expected-beat queue.
module tb_mcif_axi_slave_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        wlast_err;

  mcif_axi_slave_ram #(
    .ID_WIDTH(4), .DATA_WIDTH(64), .LEN_WIDTH(4), .DEPTH_LOG2(12)
  ) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .wlast_err(wlast_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  logic [63:0] mm [4096];
  beat_t       exp_q [$];
  logic [3:0]  exp_bid;
  logic        m_werr;
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] got [16];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting at %0t", nm, $time);
  endtask

  // Per-cycle compare of everything the DUT presents on R, B and wlast_err.
  always @(negedge clk) begin
    if (!rst) begin
      chk("wlast_err", {63'd0, wlast_err}, {63'd0, m_werr});
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          timeout("spurious_rvalid");
        end else begin
          chk("rdata", rdata, exp_q[0].d);
          chk("rlast", {63'd0, rlast}, {63'd0, exp_q[0].last});
          chk("rid", {60'd0, rid}, {60'd0, exp_q[0].id});
          chk("rresp", {62'd0, rresp}, 64'd0);
          if (rready) void'(exp_q.pop_front());
        end
      end
      if (bvalid) begin
        chk("bid", {60'd0, bid}, {60'd0, exp_bid});
        chk("bresp", {62'd0, bresp}, 64'd0);
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                          input int wlast_pos, input bit gaps);
    int unsigned idx;
    int n;
    idx = int'(addr[14:3]);
    exp_bid = id;
    awaddr = addr; awlen = 4'(len); awid = id; awburst = 2'($urandom); awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) timeout("awready");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(posedge clk); #1;
      end
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == wlast_pos); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) timeout("wready");
      chk("bvalid_early", {63'd0, bvalid}, 64'd0);
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++)
        if (ws[b][k]) mm[(idx + b) % 4096][k*8 +: 8] = wd[b][k*8 +: 8];
      if ((b == wlast_pos) != (b == len)) m_werr = 1'b1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) timeout("bvalid");
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    chk("bvalid_held", {63'd0, bvalid}, 64'd1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("awready_after_b", {63'd0, awready}, 64'd1);
  endtask

  // mode 0: RREADY high, 1: random RREADY, 2: 1-1-0 pattern; abort_at >= 0 resets after that many beats.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                         input int mode, input int abort_at);
    int unsigned idx;
    int n, hs, cyc;
    bit fire;
    idx = int'(addr[14:3]);
    for (int b = 0; b <= len; b++)
      exp_q.push_back('{d: mm[(idx + b) % 4096], last: (b == len), id: id});
    araddr = addr; arlen = 4'(len); arid = id; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) timeout("arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid_t1", {63'd0, rvalid}, 64'd0);
    @(posedge clk); #1;
    chk("rvalid_t2", {63'd0, rvalid}, 64'd1);
    hs = 0; cyc = 0;
    while (hs <= len) begin
      if (abort_at >= 0 && hs == abort_at) begin
        rready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_werr = 1'b0; exp_q.delete();
        chk("abort_rvalid", {63'd0, rvalid}, 64'd0);
        chk("abort_arready", {63'd0, arready}, 64'd1);
        chk("abort_awready", {63'd0, awready}, 64'd1);
        return;
      end
      if (mode == 0) rready = 1'b1;
      else if (mode == 1) rready = 1'($urandom_range(0, 1));
      else rready = ((cyc % 3) != 2);
      fire = rvalid && rready;
      if (fire) got[hs] = rdata;
      @(posedge clk); #1;
      if (fire) hs++;
      cyc++;
      if (cyc > 300) begin timeout("read_burst"); break; end
    end
    rready = 1'b0;
    if (mode == 0) chk("burst_cycles", 64'(cyc), 64'(len + 1));
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("rvalid_after", {63'd0, rvalid}, 64'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int len, w;
    rst = 1'b1; m_werr = 1'b0; exp_bid = '0;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_awready", {63'd0, awready}, 64'd1);
    chk("rst_arready", {63'd0, arready}, 64'd1);
    chk("rst_wready", {63'd0, wready}, 64'd0);
    chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_rlast", {63'd0, rlast}, 64'd0);
    chk("rst_wlast_err", {63'd0, wlast_err}, 64'd0);

    // single beat
    wd[0] = 64'h0123_4567_89AB_CDEF; ws[0] = 8'hFF;
    do_write(32'h40, 0, 4'h5, 0, 1'b0);
    do_read(32'h40, 0, 4'hA, 0, -1);
    chk("t1_literal", got[0], 64'h0123_4567_89AB_CDEF);

    // 16-beat burst, continuous then stalled readback
    for (int b = 0; b < 16; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    do_write(32'h1000, 15, 4'h3, 15, 1'b1);
    do_read(32'h1000, 15, 4'h7, 0, -1);
    do_read(32'h1000, 15, 4'h9, 2, -1);

    // partial strobe over a pre-filled word
    wd[0] = 64'h1111_2222_3333_4444; ws[0] = 8'hFF;
    do_write(32'h2000, 0, 4'h1, 0, 1'b0);
    wd[0] = 64'hAAAA_BBBB_CCCC_DDDD; ws[0] = 8'h0F;
    do_write(32'h2000, 0, 4'h2, 0, 1'b0);
    do_read(32'h2000, 0, 4'h4, 0, -1);
    chk("t4_literal", got[0], 64'h1111_2222_CCCC_DDDD);

    // early WLAST: burst still runs four beats, flag sticks
    for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    do_write(32'h3000, 3, 4'hC, 1, 1'b0);
    chk("t5_werr", {63'd0, wlast_err}, 64'd1);
    do_read(32'h3000, 3, 4'hD, 1, -1);

    // fill the random window, then random traffic with aliased high address bits
    for (w = 0; w < 17; w++) begin
      for (int b = 0; b < 16; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
      do_write(32'(w * 128), 15, 4'(w), 15, 1'b0);
    end
    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(0, 15);
      for (int b = 0; b < 16; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'($urandom); end
      a = $urandom; a[14:3] = 12'($urandom_range(0, 255));
      do_write(a, len, 4'($urandom), len, 1'b1);
      len = $urandom_range(0, 15);
      a = $urandom; a[14:3] = 12'($urandom_range(0, 255));
      do_read(a, len, 4'($urandom), int'($urandom_range(0, 2)), -1);
    end
    chk("werr_sticky", {63'd0, wlast_err}, 64'd1);

    // index wrap at the top of the RAM
    for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    do_write(32'h0000_7FF0, 3, 4'h6, 3, 1'b0);
    do_read(32'h0000_7FF0, 3, 4'h8, 0, -1);
    do_read(32'h0, 1, 4'h8, 0, -1);
    chk("wrap_literal", got[0], wd[2]);

    // reset in the middle of a read burst
    for (int b = 0; b < 8; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    do_write(32'h5000, 7, 4'hE, 7, 1'b0);
    do_read(32'h5000, 7, 4'hF, 0, 2);
    chk("t6_werr_cleared", {63'd0, wlast_err}, 64'd0);
    do_read(32'h5000, 7, 4'hB, 0, -1);
    chk("t6_beat7", got[7], wd[7]);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
